// File: rtl/cordic_pkg.sv
// Shared angle types, turn constants and the rounding/saturating shift used by the
// CORDIC phase discriminator.
package cordic_pkg;

  localparam int ANGLE_W_DEFAULT = 32;
  localparam longint unsigned FULL_TURNS = 64'd1 << ANGLE_W_DEFAULT;
  localparam longint unsigned PI_TURNS   = 64'd1 << (ANGLE_W_DEFAULT - 1);

  typedef logic signed [ANGLE_W_DEFAULT-1:0] angle_t;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } disc_state_e;

  // diff arrives sign-extended to 64 bits, so adding the half-LSB can never wrap.
  // Only the positive side can exceed the output range: the most negative diff
  // shifts down to exactly -2^(out_w-1).
  function automatic logic signed [63:0] round_shift_sat(
    input logic signed [63:0] diff,
    input int                 s,
    input int                 out_w
  );
    logic signed [63:0] v;
    logic signed [63:0] lim;
    v = diff;
    if (s > 0) begin
      v = v + (64'sd1 <<< (s - 1));
    end
    v   = v >>> s;
    lim = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    if (v > lim) begin
      v = lim;
    end
    return v;
  endfunction

endpackage

// File: rtl/cordic_pipe_reg.sv
// Single-entry valid/ready register stage; accepts new data whenever it is empty
// or being drained in the same cycle.
module cordic_pipe_reg
  import cordic_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready  = !r_valid || out_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid && in_ready) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cordic_phase_discriminator.sv
// FM discriminator: wrapped phase step between consecutive samples with magnitude squelch.
// Optional transfer statistics ports out_cnt/sq_cnt under CORDIC_DISC_STATS_EN.
//   state    | meaning
//   ST_PRIME | no reference phase yet; next accepted sample only loads prev_theta
//   ST_RUN   | each accepted sample emits one dphase/squelch output
module cordic_phase_discriminator
  import cordic_pkg::*;
#(
  parameter int XY_W      = 16,
  parameter int ANGLE_W   = ANGLE_W_DEFAULT,
  parameter int OUT_W     = 16,
  parameter int SQ_THRESH = 1000,
  parameter int SQ_HOLD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XY_W-1:0]    mag,
  input  logic [ANGLE_W-1:0] theta,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   dphase,
  output logic               squelch
`ifdef CORDIC_DISC_STATS_EN
  ,
  output logic [31:0]        out_cnt,
  output logic [31:0]        sq_cnt
`endif
);

  localparam int S = ANGLE_W - OUT_W;

  disc_state_e        r_state;
  logic [ANGLE_W-1:0] r_prev_theta;
  logic [7:0]         r_hold_cnt;

  logic               w_accept;
  logic               w_push;
  logic [ANGLE_W-1:0] w_diff;
  logic [OUT_W-1:0]   w_dphase;
  logic               w_weak;
  logic               w_sq;
  logic [OUT_W:0]     w_push_data;
  logic [OUT_W:0]     w_out_data;

  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && !clear && (r_state == ST_RUN);

  // Modular subtraction gives the wrapped difference; sign-extend before rounding.
  assign w_diff   = theta - r_prev_theta;
  assign w_dphase = OUT_W'(round_shift_sat({{(64-ANGLE_W){w_diff[ANGLE_W-1]}}, w_diff}, S, OUT_W));

  assign w_weak      = mag[XY_W-1] || (32'(mag) < 32'(SQ_THRESH));
  assign w_sq        = w_weak || (r_hold_cnt != 8'd0);
  assign w_push_data = {w_sq, (w_sq ? {OUT_W{1'b0}} : w_dphase)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_PRIME;
      r_prev_theta <= '0;
      r_hold_cnt   <= 8'd0;
    end else if (clear) begin
      // A sample accepted alongside clear becomes the new reference.
      r_hold_cnt <= 8'd0;
      if (w_accept) begin
        r_prev_theta <= theta;
        r_state      <= ST_RUN;
      end else begin
        r_state <= ST_PRIME;
      end
    end else if (w_accept) begin
      r_prev_theta <= theta;
      r_state      <= ST_RUN;
      if (r_state == ST_RUN) begin
        if (w_weak) begin
          r_hold_cnt <= 8'(SQ_HOLD);
        end else if (r_hold_cnt != 8'd0) begin
          r_hold_cnt <= r_hold_cnt - 8'd1;
        end
      end
    end
  end

  cordic_pipe_reg #(
    .W (OUT_W + 1)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_push),
    .in_ready  (in_ready),
    .in_data   (w_push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_data)
  );

  assign squelch = w_out_data[OUT_W];
  assign dphase  = w_out_data[OUT_W-1:0];

`ifdef CORDIC_DISC_STATS_EN
  logic        w_xfer;
  logic [31:0] r_out_cnt;
  logic [31:0] r_sq_cnt;

  assign w_xfer  = out_valid && out_ready;
  assign out_cnt = r_out_cnt;
  assign sq_cnt  = r_sq_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= 32'd0;
      r_sq_cnt  <= 32'd0;
    end else if (w_xfer) begin
      if (r_out_cnt != 32'hFFFF_FFFF) begin
        r_out_cnt <= r_out_cnt + 32'd1;
      end
      if (squelch && (r_sq_cnt != 32'hFFFF_FFFF)) begin
        r_sq_cnt <= r_sq_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cordic_phase_discriminator.sv
// Self-checking bench for cordic_phase_discriminator: directed vector table,
// backpressure, random stalls against a reference model, clear and reset cases.
module tb_cordic_phase_discriminator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mag;
  logic [31:0] theta;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dphase;
  logic        squelch;
`ifdef CORDIC_DISC_STATS_EN
  logic [31:0] out_cnt;
  logic [31:0] sq_cnt;
`endif

  always #5 clk = ~clk;

  cordic_phase_discriminator #(
    .XY_W      (16),
    .ANGLE_W   (32),
    .OUT_W     (16),
    .SQ_THRESH (1000),
    .SQ_HOLD   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .theta     (theta),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dphase    (dphase),
    .squelch   (squelch)
`ifdef CORDIC_DISC_STATS_EN
    ,
    .out_cnt   (out_cnt),
    .sq_cnt    (sq_cnt)
`endif
  );

  typedef struct {
    logic [15:0] vmag;
    logic [31:0] vtheta;
    logic        vclr;
    bit          ev;
    logic [15:0] ed;
    logic        es;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  vec_t vecs[23];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   stall_en = 1'b0;

  logic [31:0] m_prev;
  bit          m_run;
  int          m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got dphase 0x%0h with nothing expected at %0t", dphase, $time);
      end else begin
        e_mon = q.pop_front();
        check("dphase", 32'(dphase), 32'(e_mon.d));
        check("squelch", 32'(squelch), 32'(e_mon.s));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic model(input logic [15:0] m, input logic [31:0] th, input logic clr);
    longint d;
    longint r;
    exp_t   e;
    if (clr) begin
      m_hold = 0;
      m_prev = th;
      m_run  = 1'b1;
    end else if (!m_run) begin
      m_prev = th;
      m_run  = 1'b1;
    end else begin
      d = longint'($signed(th - m_prev));
      r = (d + 32768) >>> 16;
      if (r > 32767) r = 32767;
      if ($signed(m) < 1000) begin
        e = '{d: 16'h0, s: 1'b1};
        m_hold = 2;
      end else if (m_hold > 0) begin
        e = '{d: 16'h0, s: 1'b1};
        m_hold--;
      end else begin
        e = '{d: r[15:0], s: 1'b0};
      end
      q.push_back(e);
      m_prev = th;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sample has been accepted.
  task automatic send(input logic [15:0] m, input logic [31:0] th, input logic clr,
                      input bit use_model, input bit ev, input logic [15:0] ed, input logic es);
    int n;
    in_valid = 1'b1;
    mag      = m;
    theta    = th;
    clear    = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 1000 cycles");
    end else if (use_model) begin
      model(m, th, clr);
    end else if (ev) begin
      q.push_back('{d: ed, s: es});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d outputs pending expected 0", name, q.size());
    end
  endtask

  initial begin
    vecs[0]  = '{16'd20000, 32'h1000_0000, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{16'd20000, 32'h2000_0000, 1'b0, 1'b1, 16'h1000, 1'b0};
    vecs[2]  = '{16'd20000, 32'h7F00_0000, 1'b0, 1'b1, 16'h5F00, 1'b0};
    vecs[3]  = '{16'd20000, 32'h8100_0000, 1'b0, 1'b1, 16'h0200, 1'b0};
    vecs[4]  = '{16'd20000, 32'h7F00_0000, 1'b0, 1'b1, 16'hFE00, 1'b0};
    vecs[5]  = '{16'd20000, 32'h7F00_8000, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[6]  = '{16'd20000, 32'hFF00_0000, 1'b0, 1'b1, 16'h7FFF, 1'b0};
    vecs[7]  = '{16'd20000, 32'h7F00_0000, 1'b0, 1'b1, 16'h8000, 1'b0};
    vecs[8]  = '{16'd100,   32'h8000_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[9]  = '{16'd20000, 32'h8100_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[10] = '{16'd20000, 32'h8200_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[11] = '{16'd20000, 32'h8300_0000, 1'b0, 1'b1, 16'h0100, 1'b0};
    vecs[12] = '{16'hFFFB,  32'h8400_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[13] = '{16'd20000, 32'h1000_0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[14] = '{16'd20000, 32'h1040_0000, 1'b0, 1'b1, 16'h0040, 1'b0};
    vecs[15] = '{16'd999,   32'h0000_0000, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[16] = '{16'd1000,  32'h0001_0000, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[17] = '{16'd999,   32'h0002_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[18] = '{16'd20000, 32'h0003_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[19] = '{16'd20000, 32'h0004_0000, 1'b0, 1'b1, 16'h0000, 1'b1};
    vecs[20] = '{16'd20000, 32'h0005_0000, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[21] = '{16'd20000, 32'h0005_7FFF, 1'b0, 1'b1, 16'h0000, 1'b0};
    vecs[22] = '{16'd20000, 32'h0004_FFFF, 1'b0, 1'b1, 16'h0000, 1'b0};

    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    mag       = '0;
    theta     = '0;
    out_ready = 1'b1;
    m_prev    = '0;
    m_run     = 1'b0;
    m_hold    = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_dphase", 32'(dphase), 32'd0);
    check("reset_squelch", 32'(squelch), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      send(vecs[i].vmag, vecs[i].vtheta, vecs[i].vclr, 1'b0, vecs[i].ev, vecs[i].ed, vecs[i].es);
    end
    wait_drain("table");

    // Backpressure: first output parks in the register while the next sample waits.
    out_ready = 1'b0;
    send(16'd20000, 32'h0006_FFFF, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    in_valid = 1'b1;
    mag      = 16'd20000;
    theta    = 32'h0009_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_dphase_stable", 32'(dphase), 32'h0002);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd20000, 32'h0009_FFFF, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0);
    wait_drain("backpressure");

    // Random stalls against the reference model; clear+accept sets a known reference.
    stall_en = 1'b1;
    send(16'd20000, $urandom, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      logic [15:0] rm;
      if ($urandom_range(0, 7) == 0) rm = 16'($urandom_range(0, 1200));
      else rm = 16'($urandom_range(1000, 32767));
      send(rm, $urandom, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("random");

    // Reset mid-burst discards the parked output immediately.
    out_ready = 1'b0;
    send(16'd20000, 32'h2222_0000, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    check("prerst_out_valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dphase", 32'(dphase), 32'd0);
    check("rst_squelch", 32'(squelch), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(16'd20000, 32'h1000_0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    send(16'd20000, 32'h1100_0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
    wait_drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
